// File: rtl/display_cmd_pkg.sv
// display_cmd_pkg
//   Shared definitions for the sprite display command bus: field positions
//   and widths of the 32-bit command word, action/type codes, the idle word,
//   and the encoder FSM state type. The display components import the same
//   package so both ends agree on the word layout.
package display_cmd_pkg;

  // Command word layout: {component, child, action, type, toggle, data}
  localparam int COMP_LSB  = 26;
  localparam int COMP_W    = 6;
  localparam int CHILD_LSB = 21;
  localparam int CHILD_W   = 5;
  localparam int ACT_LSB   = 17;
  localparam int ACT_W     = 4;
  localparam int TYPE_LSB  = 14;
  localparam int TYPE_W    = 3;
  localparam int TOG_BIT   = 13;
  localparam int DATA_LSB  = 0;
  localparam int DATA_W    = 13;

  localparam logic [ACT_W-1:0] ACT_UPDATE = 4'b0001;
  localparam logic [ACT_W-1:0] ACT_SWAP   = 4'b1111;

  localparam logic [TYPE_W-1:0] TYPE_VISFLIP = 3'd1;
  localparam logic [TYPE_W-1:0] TYPE_X       = 3'd2;
  localparam logic [TYPE_W-1:0] TYPE_Y       = 3'd3;
  localparam logic [TYPE_W-1:0] TYPE_ATTR    = 3'd4;

  // Component 0 is never addressed, so the all-zero word is a bus no-op.
  localparam logic [31:0] IDLE_WORD = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SWAP = 2'd2
  } enc_state_t;

  // Type code of update beat 0..3.
  function automatic logic [TYPE_W-1:0] beat_type(input logic [1:0] beat);
    logic [TYPE_W-1:0] t;
    case (beat)
      2'd0:    t = TYPE_VISFLIP;
      2'd1:    t = TYPE_X;
      2'd2:    t = TYPE_Y;
      default: t = TYPE_ATTR;
    endcase
    return t;
  endfunction

  // Data field of update beat 0..3; bits [12:10] are only used by beat 0.
  function automatic logic [DATA_W-1:0] beat_data(input logic [1:0] beat,
                                                  input logic       vis,
                                                  input logic       flip,
                                                  input logic [9:0] x,
                                                  input logic [9:0] y,
                                                  input logic [9:0] attr);
    logic [DATA_W-1:0] d;
    case (beat)
      2'd0:    d = {vis, flip, 11'b0};
      2'd1:    d = {3'b0, x};
      2'd2:    d = {3'b0, y};
      default: d = {3'b0, attr};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cmd_word_pack.sv
// cmd_word_pack
//   Combinational packer for one display command word.
//   Ports:
//     comp_i   [5:0]  target component ID
//     child_i  [4:0]  child component field
//     action_i [3:0]  action code
//     type_i   [2:0]  word type code
//     toggle_i        buffer_toggle bit
//     data_i   [12:0] payload
//     word_o   [31:0] packed command word
module cmd_word_pack
  import display_cmd_pkg::*;
(
  input  logic [COMP_W-1:0]  comp_i,
  input  logic [CHILD_W-1:0] child_i,
  input  logic [ACT_W-1:0]   action_i,
  input  logic [TYPE_W-1:0]  type_i,
  input  logic               toggle_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic [31:0]        word_o
);

  always_comb begin
    word_o                          = '0;
    word_o[COMP_LSB  +: COMP_W]     = comp_i;
    word_o[CHILD_LSB +: CHILD_W]    = child_i;
    word_o[ACT_LSB   +: ACT_W]      = action_i;
    word_o[TYPE_LSB  +: TYPE_W]     = type_i;
    word_o[TOG_BIT]                 = toggle_i;
    word_o[DATA_LSB  +: DATA_W]     = data_i;
  end

endmodule

// File: rtl/sprite_cmd_encoder.sv
// sprite_cmd_encoder
//   Serialises sprite update requests into four command words each and, on
//   every frame boundary, broadcasts a buffer-swap word to component IDs
//   1..MAX_COMPONENT before flipping the back-buffer index.
//   Ports:
//     clk, reset          clock; synchronous active-low reset
//     upd_valid/upd_ready request handshake (see below)
//     upd_component..upd_attr  request fields, latched at the handshake
//     frame_start         vsync pulse requesting a buffer swap
//     writedata           registered command word (idle word when quiet)
//     back_buffer         buffer index targeted by updates
//     swap_done           one-cycle pulse after the last swap word
//     swap_overrun        sticky: frame_start seen while a swap was pending
//     dbg_state           current FSM state
//
//   Handshake: a request transfers on a rising edge where upd_valid and
//   upd_ready are both high. upd_ready is registered and is high only while
//   idle with no swap pending; it does not depend on upd_valid, and the
//   requester must hold its fields stable only up to the transfer edge.
module sprite_cmd_encoder
  import display_cmd_pkg::*;
#(
  parameter int MAX_COMPONENT = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [5:0]  upd_component,
  input  logic [4:0]  upd_child,
  input  logic        upd_visible,
  input  logic        upd_flip,
  input  logic [9:0]  upd_x,
  input  logic [9:0]  upd_y,
  input  logic [9:0]  upd_attr,
  input  logic        frame_start,
  output logic [31:0] writedata,
  output logic        back_buffer,
  output logic        swap_done,
  output logic        swap_overrun,
  output enc_state_t  dbg_state
);

  localparam logic [5:0] MAX_ID = 6'(MAX_COMPONENT);

  enc_state_t  state_q, state_d;
  logic [1:0]  beat_q, beat_d;     // update beat currently on writedata
  logic [5:0]  id_q, id_d;         // swap ID currently on writedata
  logic        pending_q, pending_d;
  logic        ready_q, ready_d;
  logic        bb_q, bb_d;
  logic        done_q;
  logic        overrun_q;
  logic [31:0] wd_q, wd_d;

  // Latched request
  logic [5:0]  comp_q;
  logic [4:0]  child_q;
  logic        vis_q, flip_q;
  logic [9:0]  x_q, y_q, attr_q;

  logic        latch, enter_swap, swap_fin, emit_upd, emit_swap;
  logic [1:0]  upd_beat;
  logic [5:0]  swap_id;

  // Packer input mux
  logic [5:0]  src_comp;
  logic [4:0]  src_child;
  logic        src_vis, src_flip;
  logic [9:0]  src_x, src_y, src_attr;
  logic [COMP_W-1:0]  p_comp;
  logic [CHILD_W-1:0] p_child;
  logic [ACT_W-1:0]   p_act;
  logic [TYPE_W-1:0]  p_type;
  logic [DATA_W-1:0]  p_data;
  logic [31:0]        pack_word;

  // Next-state decision: which word (if any) is loaded at the next edge.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    id_d       = id_q;
    latch      = 1'b0;
    enter_swap = 1'b0;
    swap_fin   = 1'b0;
    emit_upd   = 1'b0;
    emit_swap  = 1'b0;
    upd_beat   = 2'd0;
    swap_id    = 6'd0;
    unique case (state_q)
      ST_IDLE: begin
        // A pending swap wins over a new request.
        if (pending_q) begin
          state_d    = ST_SWAP;
          id_d       = 6'd1;
          enter_swap = 1'b1;
          emit_swap  = 1'b1;
          swap_id    = 6'd1;
        end else if (upd_valid && ready_q) begin
          state_d  = ST_EMIT;
          beat_d   = 2'd0;
          latch    = 1'b1;
          emit_upd = 1'b1;
          upd_beat = 2'd0;
        end
      end
      ST_EMIT: begin
        if (beat_q != 2'd3) begin
          beat_d   = beat_q + 2'd1;
          emit_upd = 1'b1;
          upd_beat = beat_q + 2'd1;
        end else if (pending_q) begin
          state_d    = ST_SWAP;
          id_d       = 6'd1;
          enter_swap = 1'b1;
          emit_swap  = 1'b1;
          swap_id    = 6'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SWAP: begin
        if (id_q != MAX_ID) begin
          id_d      = id_q + 6'd1;
          emit_swap = 1'b1;
          swap_id   = id_q + 6'd1;
        end else begin
          // Always pass through IDLE for a cycle before a further swap.
          state_d  = ST_IDLE;
          swap_fin = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The first beat is packed straight from the request inputs; later beats
  // come from the latched copy so input changes cannot leak in.
  assign src_comp  = latch ? upd_component : comp_q;
  assign src_child = latch ? upd_child     : child_q;
  assign src_vis   = latch ? upd_visible   : vis_q;
  assign src_flip  = latch ? upd_flip      : flip_q;
  assign src_x     = latch ? upd_x         : x_q;
  assign src_y     = latch ? upd_y         : y_q;
  assign src_attr  = latch ? upd_attr      : attr_q;

  always_comb begin
    p_comp  = '0;
    p_child = '0;
    p_act   = '0;
    p_type  = '0;
    p_data  = '0;
    if (emit_upd) begin
      p_comp  = src_comp;
      p_child = src_child;
      p_act   = ACT_UPDATE;
      p_type  = beat_type(upd_beat);
      p_data  = beat_data(upd_beat, src_vis, src_flip, src_x, src_y, src_attr);
    end else if (emit_swap) begin
      p_comp = swap_id;
      p_act  = ACT_SWAP;
    end
  end

  cmd_word_pack u_pack (
    .comp_i   (p_comp),
    .child_i  (p_child),
    .action_i (p_act),
    .type_i   (p_type),
    .toggle_i (bb_q),
    .data_i   (p_data),
    .word_o   (pack_word)
  );

  assign wd_d = (emit_upd || emit_swap) ? pack_word : IDLE_WORD;

  // A frame_start arriving while a swap is already pending is dropped; one
  // arriving during SWAP (pending already cleared) queues the next swap.
  assign pending_d = (pending_q && !enter_swap) || (frame_start && !pending_q);
  assign ready_d   = (state_d == ST_IDLE) && !pending_d;
  assign bb_d      = swap_fin ? ~bb_q : bb_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      beat_q    <= 2'd0;
      id_q      <= 6'd0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      bb_q      <= 1'b1;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      wd_q      <= IDLE_WORD;
      comp_q    <= '0;
      child_q   <= '0;
      vis_q     <= 1'b0;
      flip_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      attr_q    <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      id_q      <= id_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      bb_q      <= bb_d;
      done_q    <= swap_fin;
      overrun_q <= overrun_q | (frame_start & pending_q);
      wd_q      <= wd_d;
      if (latch) begin
        comp_q  <= upd_component;
        child_q <= upd_child;
        vis_q   <= upd_visible;
        flip_q  <= upd_flip;
        x_q     <= upd_x;
        y_q     <= upd_y;
        attr_q  <= upd_attr;
      end
    end
  end

  assign upd_ready    = ready_q;
  assign writedata    = wd_q;
  assign back_buffer  = bb_q;
  assign swap_done    = done_q;
  assign swap_overrun = overrun_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
module tb_sprite_cmd_encoder;
  import display_cmd_pkg::*;

  localparam int MAXC = 12;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        upd_valid;
  logic        upd_ready;
  logic [5:0]  upd_component;
  logic [4:0]  upd_child;
  logic        upd_visible;
  logic        upd_flip;
  logic [9:0]  upd_x, upd_y, upd_attr;
  logic        frame_start;
  logic [31:0] writedata;
  logic        back_buffer;
  logic        swap_done;
  logic        swap_overrun;
  enc_state_t  dbg_state;

  always #5 clk = ~clk;

  sprite_cmd_encoder #(.MAX_COMPONENT(MAXC)) dut (
    .clk           (clk),
    .reset         (reset),
    .upd_valid     (upd_valid),
    .upd_ready     (upd_ready),
    .upd_component (upd_component),
    .upd_child     (upd_child),
    .upd_visible   (upd_visible),
    .upd_flip      (upd_flip),
    .upd_x         (upd_x),
    .upd_y         (upd_y),
    .upd_attr      (upd_attr),
    .frame_start   (frame_start),
    .writedata     (writedata),
    .back_buffer   (back_buffer),
    .swap_done     (swap_done),
    .swap_overrun  (swap_overrun),
    .dbg_state     (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          m_bb;      // model back-buffer index
  int          r_comp, r_child, r_vis, r_flip, r_x, r_y, r_attr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Word value straight from the field layout: plain weighted sum.
  function automatic logic [31:0] mk_word(input int comp, input int child, input int act,
                                          input int typ, input int tog, input int data);
    longint v;
    v = longint'(comp) * 64'd67108864 + longint'(child) * 64'd2097152 +
        longint'(act) * 64'd131072 + longint'(typ) * 64'd16384 +
        longint'(tog) * 64'd8192 + longint'(data);
    return v[31:0];
  endfunction

  task automatic push_update(input int comp, input int child, input int vis, input int flip,
                             input int x, input int y, input int attr);
    exp_q.push_back(mk_word(comp, child, 1, 1, m_bb, vis * 4096 + flip * 2048));
    exp_q.push_back(mk_word(comp, child, 1, 2, m_bb, x));
    exp_q.push_back(mk_word(comp, child, 1, 3, m_bb, y));
    exp_q.push_back(mk_word(comp, child, 1, 4, m_bb, attr));
  endtask

  task automatic push_swap();
    for (int id = 1; id <= MAXC; id++) exp_q.push_back(mk_word(id, 0, 15, 0, m_bb, 0));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int comp, input int child, input int vis, input int flip,
                           input int x, input int y, input int attr);
    r_comp = comp; r_child = child; r_vis = vis; r_flip = flip;
    r_x = x; r_y = y; r_attr = attr;
    upd_component = 6'(comp);
    upd_child     = 5'(child);
    upd_visible   = 1'(vis);
    upd_flip      = 1'(flip);
    upd_x         = 10'(x);
    upd_y         = 10'(y);
    upd_attr      = 10'(attr);
  endtask

  task automatic rand_req();
    drive_req($urandom_range(1, 63), $urandom_range(0, 31), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 1023));
  endtask

  // Handshake the currently driven request and queue its four words.
  task automatic send();
    chk("ready_before_send", 32'(upd_ready), 32'd1);
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    push_update(r_comp, r_child, r_vis, r_flip, r_x, r_y, r_attr);
  endtask

  // Compare n consecutive bus words against the expected queue.
  task automatic drain(input int n);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        chk("exp_queue_empty", writedata, 32'hDEADBEEF);
      end else begin
        e = exp_q.pop_front();
        chk("writedata", writedata, e);
      end
      chk("ready_busy", 32'(upd_ready), 32'd0);
      chk("swap_done_busy", 32'(swap_done), 32'd0);
      step();
    end
  endtask

  task automatic check_swap_end();
    chk("swap_done_pulse", 32'(swap_done), 32'd1);
    m_bb = 1 - m_bb;
    chk("back_buffer_flip", 32'(back_buffer), 32'(m_bb));
    chk("idle_after_swap", writedata, 32'h0);
    step();
    chk("swap_done_low", 32'(swap_done), 32'd0);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0; upd_valid = 1'b0; frame_start = 1'b0;
    drive_req(0, 0, 0, 0, 0, 0, 0);
    m_bb = 1;
    repeat (3) step();
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_back_buffer", 32'(back_buffer), 32'd1);
    chk("rst_ready", 32'(upd_ready), 32'd0);
    chk("rst_swap_done", 32'(swap_done), 32'd0);
    chk("rst_overrun", 32'(swap_overrun), 32'd0);
    reset = 1'b1;
    step();
    chk("ready_after_rst", 32'(upd_ready), 32'd1);

    // Reference update with known bus words
    drive_req(8, 0, 1, 0, 100, 200, 5);
    send();
    chk("t1_w1", writedata, 32'h20027000);
    drain(1);
    chk("t1_w2", writedata, 32'h2002A064);
    drain(1);
    chk("t1_w3", writedata, 32'h2002E0C8);
    drain(1);
    chk("t1_w4", writedata, 32'h20032005);
    drain(1);
    chk("t1_idle", writedata, 32'h0);
    chk("t1_ready_t5", 32'(upd_ready), 32'd1);

    // Swap from idle
    pulse_frame();
    chk("pending_idle_word", writedata, 32'h0);
    chk("pending_ready", 32'(upd_ready), 32'd0);
    step();
    push_swap();
    drain(7);
    chk("swap_id8", writedata, 32'h201E2000);
    drain(5);
    check_swap_end();
    chk("ready_after_swap", 32'(upd_ready), 32'd1);
    drive_req(8, 0, 1, 0, $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
    send();
    chk("t2_post_w1", writedata, 32'h20025000);
    drain(4);

    // frame_start on the second beat: swap follows the update directly
    rand_req();
    send();
    drain(1);
    frame_start = 1'b1;
    drain(1);
    frame_start = 1'b0;
    push_swap();
    drain(14);
    check_swap_end();

    // Two frame_start pulses before the swap starts: one swap, overrun set
    rand_req();
    send();
    frame_start = 1'b1;
    drain(1);
    frame_start = 1'b0;
    drain(1);
    frame_start = 1'b1;
    drain(1);
    frame_start = 1'b0;
    push_swap();
    drain(13);
    check_swap_end();
    chk("overrun_set", 32'(swap_overrun), 32'd1);
    chk("no_second_swap", writedata, 32'h0);
    chk("ready_no_second", 32'(upd_ready), 32'd1);
    step();
    chk("still_idle", writedata, 32'h0);

    // Valid held with changing fields: only latched words, next at t+5
    rand_req();
    upd_valid = 1'b1;
    step();
    push_update(r_comp, r_child, r_vis, r_flip, r_x, r_y, r_attr);
    for (int i = 0; i < 4; i++) begin
      chk("held_word", writedata, exp_q.pop_front());
      chk("held_ready", 32'(upd_ready), 32'd0);
      rand_req();
      step();
    end
    chk("held_t5_idle", writedata, 32'h0);
    chk("held_t5_ready", 32'(upd_ready), 32'd1);
    step();
    upd_valid = 1'b0;
    push_update(r_comp, r_child, r_vis, r_flip, r_x, r_y, r_attr);
    drain(4);

    // Component 0 is emitted as given
    drive_req(0, $urandom_range(0, 31), 1, 1, $urandom_range(0, 1023), $urandom_range(0, 1023),
              $urandom_range(0, 1023));
    send();
    drain(4);
    chk("comp0_no_overrun_change", 32'(swap_overrun), 32'd1);

    // Random updates
    for (int k = 0; k < 6; k++) begin
      rand_req();
      send();
      drain(4);
    end

    // Reset during the third swap word
    pulse_frame();
    step();
    push_swap();
    drain(2);
    chk("swap_id3_before_rst", writedata, exp_q.pop_front());
    exp_q.delete();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("midrst_writedata", writedata, 32'h0);
      chk("midrst_back_buffer", 32'(back_buffer), 32'd1);
      chk("midrst_ready", 32'(upd_ready), 32'd0);
      chk("midrst_overrun", 32'(swap_overrun), 32'd0);
    end
    m_bb = 1;
    reset = 1'b1;
    step();
    chk("post_rst_ready", 32'(upd_ready), 32'd1);
    chk("post_rst_writedata", writedata, 32'h0);
    step();
    chk("post_rst_no_swap", writedata, 32'h0);
    rand_req();
    send();
    drain(4);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_cmd_encoder.md
# sprite_cmd_encoder

Command-word transmitter for the sprite display bus. Accepts per-sprite update requests from the game-logic side over a valid/ready handshake and serialises each one into the 32-bit `writedata` command words consumed by every `*_display` component. On each frame boundary it broadcasts the buffer-swap command to all component IDs and flips its back-buffer index, giving the display components ping-pong (double-buffered) updates.

## Interface
- `MAX_COMPONENT`, default 12: highest component ID that receives the swap broadcast. IDs 1..MAX_COMPONENT receive it; legal range 1..63.
- `clk` input 1: single clock for the whole block.
- `reset` input 1: synchronous, active-low. Low at a rising edge resets the block.
- `upd_valid` input 1: update request valid.
- `upd_ready` output 1: update request accepted when `upd_valid && upd_ready` at a rising edge.
- `upd_component` input 6: target component ID, 1..63. ID 0 is reserved as idle.
- `upd_child` input 5: child component field, passed through unchanged.
- `upd_visible` input 1: visibility bit.
- `upd_flip` input 1: flip bit.
- `upd_x` input 10: X position.
- `upd_y` input 10: Y position.
- `upd_attr` input 10: additional attributes.
- `frame_start` input 1: single-cycle pulse at vsync that requests a buffer swap.
- `writedata` output 32: command word to the display bus. Registered.
- `back_buffer` output 1: buffer index currently targeted by updates.
- `swap_done` output 1: one-cycle pulse after the last swap word is emitted.
- `swap_overrun` output 1: sticky flag. Set when `frame_start` arrives while a swap is already pending. Cleared only by reset.

## Operation
- Word format:
  - [31:26] component
  - [25:21] child
  - [20:17] action
  - [16:14] type
  - [13] buffer_toggle
  - [12:0] data
- Idle word is 32'h0 (component 0). Display components ignore it. `writedata` carries the idle word on every cycle that is not emitting a command.
- Update sequence: action 4'b0001, buffer_toggle = `back_buffer`. Four words, in this order:
  1. type 001, data[12] = visible, data[11] = flip, other data bits 0.
  2. type 010, data[9:0] = x.
  3. type 011, data[9:0] = y.
  4. type 100, data[9:0] = attr.
- In every update word, data[12:10] is 0 unless stated otherwise above.
- Swap sequence:
  - One word per ID, from ID 1 up to MAX_COMPONENT.
  - Each word: action 4'b1111, buffer_toggle = `back_buffer`, child/type/data 0.
  - After the final word, `back_buffer` inverts.
- FSM states: IDLE, EMIT (beat counter 0..3), SWAP (ID counter).
  - IDLE → EMIT on handshake; the request fields are latched.
  - EMIT → IDLE after beat 3, or EMIT → SWAP after beat 3 if a swap is pending.
  - IDLE → SWAP when a swap is pending; this takes priority over `upd_valid`.
  - SWAP → IDLE after ID MAX_COMPONENT.
- `upd_ready` = (state == IDLE) && !swap_pending.
- `frame_start` sets swap_pending. swap_pending clears on entry to SWAP.
- `frame_start` during SWAP sets swap_pending again, so one further swap follows.
- `frame_start` while swap_pending is already set is dropped and sets `swap_overrun`.
- The request fields are latched at the handshake. Input changes after acceptance do not affect the words already in flight.
- `upd_component` = 0 is accepted and emitted as given. The word acts as a no-op on the bus. No error is flagged.

## Timing
- Reset values:
  - `writedata` = 32'h0.
  - `back_buffer` = 1. With the bus idle during reset, display components select buffer 0, so the back buffer is 1.
  - `upd_ready` = 0 during reset, 1 on the first cycle after reset.
  - `swap_done` = 0, `swap_overrun` = 0, state IDLE, swap_pending = 0.
- Handshake at edge t → update words on `writedata` during cycles t+1..t+4 → idle word or first swap word at t+5. `upd_ready` is low during t+1..t+4 and returns high at t+5 if nothing is pending.
- Swap takes exactly MAX_COMPONENT cycles.
  - `back_buffer` changes and `swap_done` pulses in the cycle after the final swap word.
  - In that same cycle, a direct SWAP→SWAP restart is not allowed: the FSM returns to IDLE for one cycle first.
- `frame_start` in the same cycle as a handshake: the update is accepted, and the swap follows its 4 words using the same `back_buffer`.
- Reset asserted mid-sequence: the next cycle shows the idle word, the latched request and pending swap are discarded, and `back_buffer` returns to 1.

## Structure
- Package `display_cmd_pkg`:
  - field LSB/width localparams
  - ACT_UPDATE = 4'b0001, ACT_SWAP = 4'b1111
  - TYPE_VISFLIP/TYPE_X/TYPE_Y/TYPE_ATTR = 3'd1..3'd4
  - IDLE_WORD
  - enum `enc_state_t`
- The display components import the same package.
- Sub-module `cmd_word_pack`: combinational packer taking component, child, action, type, toggle and data, and returning the 32-bit word. It is instantiated once; the FSM muxes its inputs.

## Test plan
- Reset, then update {comp 8, child 0, vis 1, flip 0, x 100, y 200, attr 5} → `writedata` = 0x20027000, 0x2002A064, 0x2002E0C8, 0x20032005 on consecutive cycles, then 0x0.
- MAX_COMPONENT = 12, `frame_start` pulse while idle → 12 swap words, ID 8's word = 0x201E2000. `swap_done` pulses once, `back_buffer` goes to 0, and a subsequent update's word 1 for comp 8 = 0x20025000.
- `frame_start` on the second beat of an update → the remaining update beats complete unchanged, then the swap follows immediately. `upd_ready` stays low throughout.
- Two `frame_start` pulses before the swap begins → exactly one swap is emitted and `swap_overrun` = 1.
- `upd_valid` held with changing fields during EMIT → only the latched request's words appear. The next request is accepted at t+5.
- `reset` driven low during the third swap word → `writedata` = 0x0, `back_buffer` = 1 and `upd_ready` = 0 while reset is held; `upd_ready` = 1 one cycle after release.
